// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and receiver state encoding for the UART
//                receive path of the PicoSoC.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Clocks per bit for 115200 baud from the 100 MHz system clock
    localparam int CLK_DIV_115200 = 868;

    // 8N1 framing
    localparam int DATA_BITS = 8;

    // Receiver FSM encoding
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t ST_IDLE  = 2'd0;
    localparam rx_state_t ST_START = 2'd1;
    localparam rx_state_t ST_DATA  = 2'd2;
    localparam rx_state_t ST_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head entry is
//                always presented on head; pointers carry one extra wrap bit
//                so full/empty are distinguished without a separate counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status flags and accept logic; a push into a full FIFO is only taken
    // when a pop frees the head slot in the same cycle
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem_q[rd_ptr_q[AW-1:0]];
        count   = CNT_W'(wr_ptr_q - rd_ptr_q);
    end

    // Next pointer and storage values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless while empty so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 8N1 UART receiver with a first-word-fall-through byte FIFO,
//                one-cycle frame error pulse and sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_115200,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rxd,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV/2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_meta_d;
    logic                 rxs_q, rxs_d;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 timer_zero;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;

    assign timer_zero = (timer_q == '0);
    assign pop        = rd_en && !fifo_empty;

    // Two-flop synchroniser for the asynchronous serial line
    always_comb begin
        rx_meta_d = rxd;
        rxs_d     = rx_meta_q;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; STOP returns to IDLE at the mid-stop sample so
    // a following start edge is caught without waiting out the stop bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rxs_q) state_d = ST_START;
            ST_START: if (timer_zero) state_d = rxs_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (timer_zero && (bit_idx_q == LAST_BIT)) state_d = ST_STOP;
            ST_STOP:  if (timer_zero) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: bit timer, bit index, shift register, push and error pulse
    always_comb begin
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) timer_d = HALF_LOAD;
            end
            ST_START: begin
                if (timer_zero) begin
                    timer_d   = FULL_LOAD;
                    bit_idx_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_zero) begin
                    shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
                    timer_d   = FULL_LOAD;
                    bit_idx_d = bit_idx_q + BW'(1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_zero) begin
                    push_d      = rxs_q;
                    frame_err_d = !rxs_q;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                timer_d = '0;
            end
        endcase
    end

    // Sticky overrun: set on a dropped byte, err_clr clears, set wins
    always_comb begin
        overrun_d = overrun_q;
        if (err_clr) overrun_d = 1'b0;
        if (push_q && fifo_full && !pop) overrun_d = 1'b1;
    end

    // Synchroniser and receiver datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_q),
        .push_data (shift_q),
        .pop       (rd_en),
        .head      (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

    assign rd_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo with a short
//                bit period (16 clocks) and a 16-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 5;

    logic             clk     = 1'b0;
    logic             resetn  = 1'b0;
    logic             rxd     = 1'b1;
    logic             rd_en   = 1'b0;
    logic             err_clr = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] count;
    logic             frame_err;
    logic             overrun;

    int err_cnt = 0;
    int chk_cnt = 0;
    int fe_cnt  = 0;
    int fe_base = 0;

    uart_rx_fifo #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Count frame error pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // One 8N1 frame. pop_tick raises rd_en for that bit-time tick;
    // rst_tick holds resetn low from that tick to the end of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int pop_tick, input int rst_tick);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int j = 0; j < CLK_DIV*10; j++) begin
            rxd   = bits[j/CLK_DIV];
            rd_en = (j == pop_tick);
            if (rst_tick >= 0 && j >= rst_tick) resetn = 1'b0;
            if (rst_tick >= 0 && j == rst_tick + 1) begin
                check_eq("rst_mid_valid", 32'(rd_valid), 32'd0);
                check_eq("rst_mid_count", 32'(count), 32'd0);
            end
            tick();
        end
        rxd    = 1'b1;
        rd_en  = 1'b0;
        resetn = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        resetn = 1'b1;
        tick();

        // Pop on empty has no effect
        pop_one();
        check_eq("empty_pop_count", 32'(count), 32'd0);
        check_eq("empty_pop_valid", 32'(rd_valid), 32'd0);

        // Basic byte
        send_frame(8'hA5, 1'b1, -1, -1);
        check_eq("a5_valid", 32'(rd_valid), 32'd1);
        check_eq("a5_data", 32'(rd_data), 32'hA5);
        check_eq("a5_count", 32'(count), 32'd1);
        pop_one();
        check_eq("a5_pop_valid", 32'(rd_valid), 32'd0);
        check_eq("a5_pop_count", 32'(count), 32'd0);

        // Glitch shorter than half a bit is rejected
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (20) tick();
        check_eq("glitch_count", 32'(count), 32'd0);
        check_eq("glitch_valid", 32'(rd_valid), 32'd0);
        check_eq("glitch_ferr", 32'(fe_cnt), 32'd0);
        check_eq("glitch_state", 32'(dut.state_q), 32'd0);
        send_frame(8'h3C, 1'b1, -1, -1);
        check_eq("3c_data", 32'(rd_data), 32'h3C);
        check_eq("3c_count", 32'(count), 32'd1);
        pop_one();

        // Stop bit low: one frame error, nothing stored
        fe_base = fe_cnt;
        send_frame(8'h55, 1'b0, -1, -1);
        repeat (20) tick();
        check_eq("ferr_pulses", 32'(fe_cnt - fe_base), 32'd1);
        check_eq("ferr_count", 32'(count), 32'd0);

        // Overflow: 17 bytes, last one dropped
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, -1, -1);
        check_eq("ovf_count", 32'(count), 32'd16);
        check_eq("ovf_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("ovf_drain", 32'(rd_data), 32'(i));
            pop_one();
        end
        check_eq("ovf_drained", 32'(count), 32'd0);
        check_eq("ovf_sticky", 32'(overrun), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("ovf_clr", 32'(overrun), 32'd0);

        // Full FIFO with pop on the push cycle: no overrun
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1, -1, -1);
        check_eq("full_count", 32'(count), 32'd16);
        check_eq("full_head", 32'(rd_data), 32'h00);
        send_frame(8'h10, 1'b1, 155, -1);
        check_eq("fpp_count", 32'(count), 32'd16);
        check_eq("fpp_ovr", 32'(overrun), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            check_eq("fpp_drain", 32'(rd_data), 32'(i));
            pop_one();
        end
        check_eq("fpp_empty", 32'(rd_valid), 32'd0);

        // Reset mid-frame discards buffered and partial data
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        check_eq("pre_rst_count", 32'(count), 32'd2);
        send_frame(8'h81, 1'b1, -1, 60);
        check_eq("post_rst_count", 32'(count), 32'd0);
        check_eq("post_rst_valid", 32'(rd_valid), 32'd0);
        check_eq("post_rst_state", 32'(dut.state_q), 32'd0);
        send_frame(8'h7E, 1'b1, -1, -1);
        check_eq("7e_data", 32'(rd_data), 32'h7E);
        check_eq("7e_count", 32'(count), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
